// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one main-memory block port between the I-cache (port 0)
// and the D-cache (port 1); runs writeback-then-fill and returns the block with a done pulse.
module cache_mem_arbiter #(
  parameter int PA_WIDTH  = 32,
  parameter int BLK_WIDTH = 512
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PA_WIDTH-1:0]  c0_addr,
  input  logic [PA_WIDTH-1:0]  c0_wb_addr,
  input  logic                 c0_rd_en,
  input  logic                 c0_wr_en,
  input  logic [BLK_WIDTH-1:0] c0_wr_blk,
  output logic [BLK_WIDTH-1:0] c0_rd_blk,
  output logic                 c0_done,
  input  logic [PA_WIDTH-1:0]  c1_addr,
  input  logic [PA_WIDTH-1:0]  c1_wb_addr,
  input  logic                 c1_rd_en,
  input  logic                 c1_wr_en,
  input  logic [BLK_WIDTH-1:0] c1_wr_blk,
  output logic [BLK_WIDTH-1:0] c1_rd_blk,
  output logic                 c1_done,
  output logic [PA_WIDTH-1:0]  mem_addr,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [BLK_WIDTH-1:0] mem_wr_blk,
  input  logic [BLK_WIDTH-1:0] mem_rd_blk,
  input  logic                 mem_ready,
  output logic                 busy,
  output logic                 gnt_id
);

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

  state_t                state_reg;
  logic                  last_gnt_reg;
  logic                  gnt_reg;
  logic                  rd_flag_reg;
  logic [PA_WIDTH-1:0]   addr_reg;
  logic [BLK_WIDTH-1:0]  rsp_reg;
  logic [1:0]            done_reg;

  logic [1:0]            req;
  logic                  sel;
  logic                  sel_rd;
  logic                  sel_wr;
  logic [PA_WIDTH-1:0]   sel_addr;
  logic [PA_WIDTH-1:0]   sel_wb_addr;
  logic [BLK_WIDTH-1:0]  sel_blk;

  assign req = {c1_rd_en | c1_wr_en, c0_rd_en | c0_wr_en};

  // On a tie the port that did not win last time gets the memory.
  always_comb begin
    sel = 1'b0;
    if (req[1] && !req[0])
      sel = 1'b1;
    else if (req[1] && req[0])
      sel = ~last_gnt_reg;
  end

  always_comb begin
    sel_rd      = c0_rd_en;
    sel_wr      = c0_wr_en;
    sel_addr    = c0_addr;
    sel_wb_addr = c0_wb_addr;
    sel_blk     = c0_wr_blk;
    if (sel) begin
      sel_rd      = c1_rd_en;
      sel_wr      = c1_wr_en;
      sel_addr    = c1_addr;
      sel_wb_addr = c1_wb_addr;
      sel_blk     = c1_wr_blk;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      last_gnt_reg <= 1'b1;
      gnt_reg      <= 1'b0;
      rd_flag_reg  <= 1'b0;
      addr_reg     <= '0;
      rsp_reg      <= '0;
      done_reg     <= '0;
      busy         <= 1'b0;
      mem_addr     <= '0;
      mem_rd_en    <= 1'b0;
      mem_wr_en    <= 1'b0;
      mem_wr_blk   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req) begin
            gnt_reg      <= sel;
            last_gnt_reg <= sel;
            busy         <= 1'b1;
            addr_reg     <= sel_addr;
            rd_flag_reg  <= sel_rd;
            mem_wr_blk   <= sel_blk;
            if (sel_wr) begin
              mem_wr_en <= 1'b1;
              mem_addr  <= sel_wb_addr;
              state_reg <= WB;
            end else begin
              mem_rd_en <= 1'b1;
              mem_addr  <= sel_addr;
              state_reg <= FILL;
            end
          end
        end
        WB: begin
          if (mem_ready) begin
            mem_wr_en <= 1'b0;
            // Fill follows immediately; no idle cycle between the two memory ops.
            if (rd_flag_reg) begin
              mem_rd_en <= 1'b1;
              mem_addr  <= addr_reg;
              state_reg <= FILL;
            end else begin
              done_reg[gnt_reg] <= 1'b1;
              state_reg         <= DONE;
            end
          end
        end
        FILL: begin
          if (mem_ready) begin
            mem_rd_en         <= 1'b0;
            rsp_reg           <= mem_rd_blk;
            done_reg[gnt_reg] <= 1'b1;
            state_reg         <= DONE;
          end
        end
        DONE: begin
          done_reg  <= '0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt_id    = gnt_reg;
  assign c0_done   = done_reg[0];
  assign c1_done   = done_reg[1];
  assign c0_rd_blk = rsp_reg;
  assign c1_rd_blk = rsp_reg;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: cycle-exact memory responses driven inline,
// completions checked against a scoreboard of expected port/data.
module tb_cache_mem_arbiter;
  localparam int PA  = 32;
  localparam int BLK = 512;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [PA-1:0]  c0_addr, c0_wb_addr, c1_addr, c1_wb_addr;
  logic           c0_rd_en, c0_wr_en, c1_rd_en, c1_wr_en;
  logic [BLK-1:0] c0_wr_blk, c1_wr_blk, c0_rd_blk, c1_rd_blk;
  logic           c0_done, c1_done;
  logic [PA-1:0]  mem_addr;
  logic           mem_rd_en, mem_wr_en, mem_ready;
  logic [BLK-1:0] mem_wr_blk, mem_rd_blk;
  logic           busy, gnt_id;

  int total = 0;
  int bad   = 0;
  logic last_gnt_m;

  bit             exp_port_q[$];
  bit             exp_chk_q[$];
  logic [BLK-1:0] exp_data_q[$];

  always #5 clk = ~clk;

  cache_mem_arbiter #(.PA_WIDTH(PA), .BLK_WIDTH(BLK)) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_addr(c0_addr), .c0_wb_addr(c0_wb_addr), .c0_rd_en(c0_rd_en), .c0_wr_en(c0_wr_en),
    .c0_wr_blk(c0_wr_blk), .c0_rd_blk(c0_rd_blk), .c0_done(c0_done),
    .c1_addr(c1_addr), .c1_wb_addr(c1_wb_addr), .c1_rd_en(c1_rd_en), .c1_wr_en(c1_wr_en),
    .c1_wr_blk(c1_wr_blk), .c1_rd_blk(c1_rd_blk), .c1_done(c1_done),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wr_blk(mem_wr_blk), .mem_rd_blk(mem_rd_blk), .mem_ready(mem_ready),
    .busy(busy), .gnt_id(gnt_id)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BLK-1:0] obs, input logic [BLK-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BLK-1:0] rblk();
    logic [BLK-1:0] r;
    for (int i = 0; i < BLK / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_req(input logic p, input logic rd, input logic wr,
                         input logic [PA-1:0] a, input logic [PA-1:0] wa,
                         input logic [BLK-1:0] b);
    if (p == 1'b0) begin
      c0_rd_en = rd; c0_wr_en = wr; c0_addr = a; c0_wb_addr = wa; c0_wr_blk = b;
    end else begin
      c1_rd_en = rd; c1_wr_en = wr; c1_addr = a; c1_wb_addr = wa; c1_wr_blk = b;
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_c0_done"}, c0_done, 0);
    chk({tag, "_c1_done"}, c1_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mem_rd_en"}, mem_rd_en, 0);
    chk({tag, "_mem_wr_en"}, mem_wr_en, 0);
  endtask

  // One memory operation: enable held for waits+1 cycles, mem_ready on the last.
  task automatic mem_phase(input logic is_wr, input logic [PA-1:0] a, input logic [BLK-1:0] blk,
                           input int waits, input logic [BLK-1:0] rdata, input logic corrupt);
    for (int k = 0; k <= waits; k++) begin
      chk("mem_wr_en", mem_wr_en, is_wr);
      chk("mem_rd_en", mem_rd_en, !is_wr);
      chk("mem_addr", mem_addr, a);
      if (is_wr) chk("mem_wr_blk", mem_wr_blk, blk);
      chk("busy_op", busy, 1);
      chk("no_early_done", c0_done | c1_done, 0);
      if (corrupt && k == 0) begin
        c0_addr    = 32'hDEAD_0000;
        c0_wb_addr = 32'hDEAD_0040;
      end
      if (k == waits) begin
        mem_ready  = 1'b1;
        mem_rd_blk = rdata;
      end
      step();
      mem_ready  = 1'b0;
      mem_rd_blk = rblk();
    end
  endtask

  // Called in the cycle where port p's request is visible and p is expected to win.
  task automatic txn(input logic p, input logic wr, input logic rd,
                     input logic [PA-1:0] wa, input logic [PA-1:0] a, input logic [BLK-1:0] wblk,
                     input int wwait, input int rwait, input logic [BLK-1:0] rdata,
                     input logic corrupt);
    bit ep, ec;
    logic [BLK-1:0] ed;
    exp_port_q.push_back(p);
    exp_chk_q.push_back(rd);
    exp_data_q.push_back(rdata);
    step();
    chk("gnt_id", gnt_id, p);
    if (wr) mem_phase(1'b1, wa, wblk, wwait, rblk(), 1'b0);
    if (rd) mem_phase(1'b0, a, '0, rwait, rdata, corrupt);
    if (exp_port_q.size() == 0) begin
      chk("sb_underflow", 1, 0);
    end else begin
      ep = exp_port_q.pop_front();
      ec = exp_chk_q.pop_front();
      ed = exp_data_q.pop_front();
      chk("c0_done", c0_done, ep == 1'b0);
      chk("c1_done", c1_done, ep == 1'b1);
      if (ec) chk("rd_blk", ep ? c1_rd_blk : c0_rd_blk, ed);
      chk("busy_done", busy, 1);
      chk("mem_idle_done", mem_rd_en | mem_wr_en, 0);
    end
    set_req(p, 1'b0, 1'b0, '0, '0, '0);
    last_gnt_m = p;
    step();
    chk_idle_outputs("idle_after");
  endtask

  initial begin
    logic p;
    logic [BLK-1:0] b;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    mem_rd_blk = '0;
    set_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
    last_gnt_m = 1'b1;
    step();
    step();
    chk_idle_outputs("reset");
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_wr_blk", mem_wr_blk, 0);
    chk("reset_rd_blk", c0_rd_blk | c1_rd_blk, 0);
    chk("reset_gnt_id", gnt_id, 0);
    rst_n = 1'b1;
    step();

    // Port 0 fill, memory ready in third enable cycle.
    set_req(1'b0, 1'b1, 1'b0, 32'h0000_1040, 32'h0, '0);
    txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_1040, '0, 0, 2, {64{8'hA5}}, 1'b0);

    // Port 1 writeback + fill, zero-wait memory.
    b = rblk();
    set_req(1'b1, 1'b1, 1'b1, 32'h0000_2000, 32'h0000_8000, b);
    txn(1'b1, 1'b1, 1'b1, 32'h0000_8000, 32'h0000_2000, b, 0, 0, rblk(), 1'b0);

    // Writeback-only request from port 0.
    b = rblk();
    set_req(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_3000, b);
    txn(1'b0, 1'b1, 1'b0, 32'h0000_3000, 32'h0, b, 1, 0, '0, 1'b0);

    // Stray mem_ready while idle must not start anything.
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk_idle_outputs("stray_ready");

    // Port 0 address changes during FILL; memory keeps the latched address.
    set_req(1'b0, 1'b1, 1'b0, 32'h0000_4400, 32'h0, '0);
    txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_4400, '0, 0, 2, rblk(), 1'b1);

    // Reset during WB with mem_ready pending.
    b = rblk();
    set_req(1'b0, 1'b1, 1'b1, 32'h0000_5000, 32'h0000_6000, b);
    step();
    chk("rst_pre_wb", mem_wr_en, 1);
    mem_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    chk("async_rst_addr", mem_addr, 0);
    chk("async_rst_blk", mem_wr_blk, 0);
    step();
    mem_ready = 1'b0;
    chk_idle_outputs("rst_held");
    set_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
    last_gnt_m = 1'b1;
    rst_n = 1'b1;
    step();
    chk_idle_outputs("rst_release");
    b = rblk();
    set_req(1'b1, 1'b1, 1'b1, 32'h0000_7000, 32'h0000_9000, b);
    txn(1'b1, 1'b1, 1'b1, 32'h0000_9000, 32'h0000_7000, b, 1, 1, rblk(), 1'b0);

    // Ties and continuous re-requests: grants must alternate.
    set_req(1'b0, 1'b1, 1'b0, 32'h0001_0000, 32'h0, '0);
    set_req(1'b1, 1'b1, 1'b0, 32'h0002_0000, 32'h0, '0);
    for (int i = 0; i < 5; i++) begin
      p = ~last_gnt_m;
      txn(p, 1'b0, 1'b1, 32'h0, p ? c1_addr : c0_addr, '0, 0, i % 2, rblk(), 1'b0);
      if (i < 3) set_req(p, 1'b1, 1'b0, 32'h0003_0000 + 32'(i * 64), 32'h0, '0);
    end

    chk("sb_empty", exp_port_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Two-port arbiter and sequencer sharing one main-memory block port between two cache_data-style clients (port 0: instruction cache, port 1: data cache). Grants one client at a time (round-robin), latches its request, and runs writeback-then-fill sequences on the memory port. Returns the filled block with a one-cycle done pulse. Sits between the cache controllers and the main-memory model.

## Interface
- PA_WIDTH, 32, physical address width
- BLK_WIDTH, 512, cache block width (64 B)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cN_addr  in  PA_WIDTH  fill (read) address, N = 0,1
- cN_wb_addr  in  PA_WIDTH  writeback address for the dirty victim
- cN_rd_en  in  1  fill requested; level, held until cN_done
- cN_wr_en  in  1  writeback requested; level, held until cN_done
- cN_wr_blk  in  BLK_WIDTH  victim block data
- cN_rd_blk  out  BLK_WIDTH  filled block, valid while cN_done=1
- cN_done  out  1  one-cycle completion pulse
- mem_addr  out  PA_WIDTH  memory address
- mem_rd_en  out  1  memory read, held until mem_ready
- mem_wr_en  out  1  memory write, held until mem_ready
- mem_wr_blk  out  BLK_WIDTH  memory write data
- mem_rd_blk  in  BLK_WIDTH  memory read data, valid with mem_ready
- mem_ready  in  1  one-cycle completion of current memory op
- busy  out  1  1 in any state other than IDLE
- gnt_id  out  1  port currently owning memory (valid while busy)

## Operation
- States: IDLE, WB, FILL, DONE. Registered outputs only.
- IDLE: port N requests if cN_rd_en|cN_wr_en. One requester: grant it. Both: grant the port != last_gnt. On grant, latch gnt_id, cN_addr, cN_wb_addr, cN_wr_blk, rd/wr flags; set last_gnt = gnt_id. Next state WB if wr flag, else FILL.
- WB: mem_wr_en=1, mem_addr=latched wb_addr, mem_wr_blk=latched block. On mem_ready: FILL if rd flag, else DONE.
- FILL: mem_rd_en=1, mem_addr=latched addr. On mem_ready: capture mem_rd_blk into rsp register; next DONE.
- DONE: c{gnt_id}_done=1 for exactly one cycle; c{gnt_id}_rd_blk = rsp register. Next IDLE. Other port's done stays 0.
- Requester inputs are ignored outside IDLE; changes after grant have no effect.
- Requester drops rd/wr at the clock edge ending its done cycle; IDLE never re-grants the same completed request.
- Writeback-only requests (wr without rd) complete through DONE; cN_rd_blk then holds the previous rsp value (don't care).
- mem_rd_en and mem_wr_en are never both 1.

## Timing
- Reset values: all cN_done=0, cN_rd_blk=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wr_blk=0, busy=0, gnt_id=0, last_gnt=1 (port 0 wins first tie), state IDLE.
- Read-only, memory ready in first enable cycle: request sampled cycle 0, mem_rd_en cycle 1, done cycle 2. Each extra memory wait cycle adds 1.
- Writeback+fill, both memory ops ready immediately: mem_wr_en cycle 1, mem_rd_en cycle 2, done cycle 3. No idle cycle between WB and FILL.
- Back-to-back: a request waiting during another port's service is granted in the IDLE cycle after DONE; minimum 1 IDLE cycle between grants.
- mem_ready while neither enable is high is ignored.
- Reset mid-operation: immediately to reset values; in-flight request dropped without done; requesters must re-issue.

## Test plan
- Port 0 read, addr 0x0000_1040, memory ready after 3 cycles, data 0xA5 pattern -> mem_rd_en cycles 1-3, c0_done cycle 4 with c0_rd_blk = pattern; c1_done stays 0.
- Port 1 wb+fill, wb_addr 0x0000_8000, addr 0x0000_2000, zero-wait memory -> mem_wr_en cycle 1 (addr 0x8000, blk = c1_wr_blk), mem_rd_en cycle 2 (addr 0x2000), c1_done cycle 3.
- Both ports request same cycle from reset -> port 0 served first, port 1 granted in IDLE after port 0's DONE; repeat ties alternate 1,0,1.
- Port 0 holds requests continuously while port 1 requests -> grants alternate, no starvation; busy low exactly one cycle between grants.
- Change c0_addr to 0xDEAD_0000 during FILL -> mem_addr keeps latched value.
- Assert rst_n=0 during WB with mem_ready pending -> all outputs 0 asynchronously, no done; after release, new port 1 request completes normally.
